// File: rtl/p4_router_queue_pkg.sv
// Shared types and helpers for the router queue page client: status codes,
// response layout, FSM states and the length-to-page-count arithmetic.
package p4_router_queue_pkg;

  localparam int PAGE_IDX_W = 10;

  typedef logic [PAGE_IDX_W-1:0] page_idx_t;

  typedef enum logic [1:0] {
    QP_OK      = 2'd0,
    QP_NOSPACE = 2'd1,
    QP_BAD     = 2'd2
  } queue_page_status_t;

  typedef struct packed {
    queue_page_status_t status;
    logic [7:0]         pages;
  } pkt_resp_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ALLOC = 2'd2,
    S_RESP  = 2'd3
  } client_state_t;

  // 17-bit so that a 0xFFFF length rounds up without wrapping
  function automatic logic [16:0] pages_for_len(input logic [15:0] len,
                                                input int unsigned page_log);
    logic [16:0] round_up;
    round_up = (17'd1 << page_log) - 17'd1;
    return ({1'b0, len} + round_up) >> page_log;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/p4_router_axis_skid_buffer.sv
// Two-entry AXI-stream register slice with a registered tready; sustains one
// beat per cycle and preserves order.
module p4_router_axis_skid_buffer
  import p4_router_queue_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             i_s_tvalid,
  output logic             o_s_tready,
  input  logic [WIDTH-1:0] i_s_tdata,
  output logic             o_m_tvalid,
  input  logic             i_m_tready,
  output logic [WIDTH-1:0] o_m_tdata
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_rdy;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_push = i_s_tvalid && r_in_rdy;
  assign w_pop  = (r_count != 2'd0) && i_m_tready;

  // occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // pointers, occupancy and the look-ahead ready
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_in_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count  <= w_count_nxt;
      r_in_rdy <= (w_count_nxt != 2'd2);
    end
  end

  // storage is not reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_s_tdata;
    end
  end

  assign o_s_tready = r_in_rdy;
  assign o_m_tvalid = (r_count != 2'd0);
  assign o_m_tdata  = r_mem[r_rd_ptr];

endmodule

// File: rtl/p4_router_queue_page_client.sv
// Client side of the queue MMU: admits packets against the free-page count,
// forwards ceil(len/PAGE_BYTES) MMU pages as a tlast-delimited chain, and
// reports per-packet status. Retired pages return to the MMU via a skid buffer.
module p4_router_queue_page_client
  import p4_router_queue_pkg::*;
#(
  parameter int NUM_PAGES_LOG = 10,
  parameter int PAGE_BYTES    = 256,
  parameter int MTU_BYTES     = 2000,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic [NUM_PAGES_LOG-1:0] i_num_free_pages,
  input  logic                     i_pkt_req_tvalid,
  output logic                     o_pkt_req_tready,
  input  logic [15:0]              i_pkt_req_tdata,
  input  logic [TAG_WIDTH-1:0]     i_pkt_req_tuser,
  input  logic                     i_page_in_tvalid,
  output logic                     o_page_in_tready,
  input  logic [NUM_PAGES_LOG-1:0] i_page_in_tdata,
  output logic                     o_page_out_tvalid,
  input  logic                     i_page_out_tready,
  output logic [NUM_PAGES_LOG-1:0] o_page_out_tdata,
  output logic [TAG_WIDTH-1:0]     o_page_out_tuser,
  output logic                     o_page_out_tlast,
  output logic                     o_pkt_resp_tvalid,
  input  logic                     i_pkt_resp_tready,
  output logic [9:0]               o_pkt_resp_tdata,
  output logic [TAG_WIDTH-1:0]     o_pkt_resp_tuser,
  input  logic                     i_release_in_tvalid,
  output logic                     o_release_in_tready,
  input  logic [NUM_PAGES_LOG-1:0] i_release_in_tdata,
  output logic                     o_release_out_tvalid,
  input  logic                     i_release_out_tready,
  output logic [NUM_PAGES_LOG-1:0] o_release_out_tdata,
  output logic [31:0]              o_cnt_nospace,
  output logic [31:0]              o_cnt_bad
);

  localparam int unsigned PAGE_LOG = $clog2(PAGE_BYTES);
  localparam logic [15:0] MTU_LEN  = 16'(MTU_BYTES);

  client_state_t          r_state;
  client_state_t          w_next;
  logic [15:0]            r_len;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [7:0]             r_pages;
  logic [7:0]             r_cnt;
  queue_page_status_t     r_status;
  logic [31:0]            r_cnt_bad;
  logic [31:0]            r_cnt_nospace;
  logic [16:0]            w_pages;
  logic                   w_bad;
  logic                   w_nospace;
  logic                   w_last;
  logic                   w_pg_hs;
  pkt_resp_t              w_resp;

  assign w_pages   = pages_for_len(r_len, PAGE_LOG);
  assign w_bad     = (r_len == 16'd0) || (r_len > MTU_LEN);
  assign w_nospace = (17'(i_num_free_pages) < w_pages);
  assign w_last    = (r_cnt == (r_pages - 8'd1));
  assign w_pg_hs   = (r_state == S_ALLOC) && i_page_in_tvalid && i_page_out_tready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and handshake controls
  always_comb begin
    w_next            = r_state;
    o_pkt_req_tready  = 1'b0;
    o_page_in_tready  = 1'b0;
    o_page_out_tvalid = 1'b0;
    o_pkt_resp_tvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_pkt_req_tready = !sreset;
        if (i_pkt_req_tvalid) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CHECK: begin
        if (w_bad || w_nospace) begin
          w_next = S_RESP;
        end else begin
          w_next = S_ALLOC;
        end
      end
      S_ALLOC: begin
        o_page_out_tvalid = i_page_in_tvalid;
        o_page_in_tready  = i_page_out_tready;
        if (w_pg_hs && w_last) begin
          w_next = S_RESP;
        end else begin
          w_next = S_ALLOC;
        end
      end
      S_RESP: begin
        o_pkt_resp_tvalid = 1'b1;
        if (i_pkt_resp_tready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // request capture, admission verdict, page counting and reject counters
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_len         <= 16'd0;
      r_tag         <= '0;
      r_pages       <= 8'd0;
      r_cnt         <= 8'd0;
      r_status      <= QP_OK;
      r_cnt_bad     <= 32'd0;
      r_cnt_nospace <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_pkt_req_tvalid) begin
            r_len <= i_pkt_req_tdata;
            r_tag <= i_pkt_req_tuser;
          end
        end
        S_CHECK: begin
          r_cnt <= 8'd0;
          if (w_bad) begin
            r_status  <= QP_BAD;
            r_pages   <= 8'd0;
            r_cnt_bad <= sat_inc32(r_cnt_bad);
          end else if (w_nospace) begin
            r_status      <= QP_NOSPACE;
            r_pages       <= 8'd0;
            r_cnt_nospace <= sat_inc32(r_cnt_nospace);
          end else begin
            r_status <= QP_OK;
            r_pages  <= w_pages[7:0];
          end
        end
        S_ALLOC: begin
          if (w_pg_hs) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_page_out_tdata = i_page_in_tdata;
  assign o_page_out_tuser = r_tag;
  assign o_page_out_tlast = w_last;

  assign w_resp           = '{status: r_status, pages: r_pages};
  assign o_pkt_resp_tdata = w_resp;
  assign o_pkt_resp_tuser = r_tag;

  assign o_cnt_bad     = r_cnt_bad;
  assign o_cnt_nospace = r_cnt_nospace;

  p4_router_axis_skid_buffer #(
    .WIDTH (NUM_PAGES_LOG)
  ) u_release_skid (
    .clk        (clk),
    .sreset     (sreset),
    .i_s_tvalid (i_release_in_tvalid),
    .o_s_tready (o_release_in_tready),
    .i_s_tdata  (i_release_in_tdata),
    .o_m_tvalid (o_release_out_tvalid),
    .i_m_tready (i_release_out_tready),
    .o_m_tdata  (o_release_out_tdata)
  );

endmodule

// File: tb/tb_p4_router_queue_page_client.sv
// Scoreboard bench: stimulus pushes expected pages/responses/release beats,
// a negedge monitor pops and compares whenever the DUT hands something out.
module tb_p4_router_queue_page_client;
  import p4_router_queue_pkg::*;

  typedef struct packed {
    logic [9:0] d;
    logic [7:0] u;
    logic       l;
  } pg_t;

  logic        clk = 1'b0;
  logic        sreset;
  logic [9:0]  free_pages;
  logic        req_valid;
  logic [15:0] req_data;
  logic [7:0]  req_tag;
  logic        pin_valid;
  logic [9:0]  pin_data;
  logic        po_ready;
  logic        rs_ready;
  logic        rl_in_valid;
  logic [9:0]  rl_in_data;
  logic        rl_out_ready;

  logic        o_pkt_req_tready, o_page_in_tready, o_page_out_tvalid, o_page_out_tlast;
  logic [9:0]  o_page_out_tdata;
  logic [7:0]  o_page_out_tuser;
  logic        o_pkt_resp_tvalid;
  logic [9:0]  o_pkt_resp_tdata;
  logic [7:0]  o_pkt_resp_tuser;
  logic        o_release_in_tready, o_release_out_tvalid;
  logic [9:0]  o_release_out_tdata;
  logic [31:0] o_cnt_nospace, o_cnt_bad;

  int vecs = 0;
  int errs = 0;

  pg_t         exp_pg_q[$];
  logic [17:0] exp_rs_q[$];
  page_idx_t   exp_rl_q[$];
  page_idx_t   mmu_q[$];

  logic pin_hs = 1'b0;
  logic pin_rdy_seen = 1'b0;
  logic bp_en = 1'b0;
  logic gap_en = 1'b0;
  logic po_stall = 1'b0, rs_stall = 1'b0, rl_stall = 1'b0;
  logic [18:0] po_prev;
  logic [17:0] rs_prev;
  logic [9:0]  rl_prev;

  always #5 clk = ~clk;

  p4_router_queue_page_client dut (
    .clk                  (clk),
    .sreset               (sreset),
    .i_num_free_pages     (free_pages),
    .i_pkt_req_tvalid     (req_valid),
    .o_pkt_req_tready     (o_pkt_req_tready),
    .i_pkt_req_tdata      (req_data),
    .i_pkt_req_tuser      (req_tag),
    .i_page_in_tvalid     (pin_valid),
    .o_page_in_tready     (o_page_in_tready),
    .i_page_in_tdata      (pin_data),
    .o_page_out_tvalid    (o_page_out_tvalid),
    .i_page_out_tready    (po_ready),
    .o_page_out_tdata     (o_page_out_tdata),
    .o_page_out_tuser     (o_page_out_tuser),
    .o_page_out_tlast     (o_page_out_tlast),
    .o_pkt_resp_tvalid    (o_pkt_resp_tvalid),
    .i_pkt_resp_tready    (rs_ready),
    .o_pkt_resp_tdata     (o_pkt_resp_tdata),
    .o_pkt_resp_tuser     (o_pkt_resp_tuser),
    .i_release_in_tvalid  (rl_in_valid),
    .o_release_in_tready  (o_release_in_tready),
    .i_release_in_tdata   (rl_in_data),
    .o_release_out_tvalid (o_release_out_tvalid),
    .i_release_out_tready (rl_out_ready),
    .o_release_out_tdata  (o_release_out_tdata),
    .o_cnt_nospace        (o_cnt_nospace),
    .o_cnt_bad            (o_cnt_bad)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    vecs++;
    errs++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Output monitor and scoreboard checker
  always @(negedge clk) begin : mon
    pg_t         e_pg;
    logic [17:0] e_rs;
    page_idx_t   e_rl;
    pin_hs = pin_valid && o_page_in_tready && !sreset;
    if (o_page_in_tready) pin_rdy_seen = 1'b1;
    if (sreset) begin
      po_stall = 1'b0;
      rs_stall = 1'b0;
      rl_stall = 1'b0;
    end else begin
      if (po_stall) chk("page_out_hold", 32'({o_page_out_tvalid, o_page_out_tdata, o_page_out_tuser, o_page_out_tlast}), 32'({1'b1, po_prev}));
      if (rs_stall) chk("pkt_resp_hold", 32'({o_pkt_resp_tvalid, o_pkt_resp_tdata, o_pkt_resp_tuser}), 32'({1'b1, rs_prev}));
      if (rl_stall) chk("release_hold", 32'({o_release_out_tvalid, o_release_out_tdata}), 32'({1'b1, rl_prev}));
      if (o_page_out_tvalid && po_ready) begin
        if (exp_pg_q.size() == 0) flag_fail("page_out_unexpected");
        else begin
          e_pg = exp_pg_q.pop_front();
          chk("page_out", 32'({o_page_out_tdata, o_page_out_tuser, o_page_out_tlast}), 32'(e_pg));
        end
      end
      if (o_pkt_resp_tvalid && rs_ready) begin
        if (exp_rs_q.size() == 0) flag_fail("pkt_resp_unexpected");
        else begin
          e_rs = exp_rs_q.pop_front();
          chk("pkt_resp", 32'({o_pkt_resp_tdata, o_pkt_resp_tuser}), 32'(e_rs));
        end
      end
      if (o_release_out_tvalid && rl_out_ready) begin
        if (exp_rl_q.size() == 0) flag_fail("release_unexpected");
        else begin
          e_rl = exp_rl_q.pop_front();
          chk("release_out", 32'(o_release_out_tdata), 32'(e_rl));
        end
      end
      po_stall = o_page_out_tvalid && !po_ready;
      po_prev  = {o_page_out_tdata, o_page_out_tuser, o_page_out_tlast};
      rs_stall = o_pkt_resp_tvalid && !rs_ready;
      rs_prev  = {o_pkt_resp_tdata, o_pkt_resp_tuser};
      rl_stall = o_release_out_tvalid && !rl_out_ready;
      rl_prev  = o_release_out_tdata;
    end
  end

  // MMU model: offers queued free pages, holds a beat until it is taken
  always @(posedge clk) begin
    #1;
    if (pin_hs) void'(mmu_q.pop_front());
    if (!(pin_valid && !pin_hs)) begin
      if (mmu_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        pin_valid = 1'b1;
        pin_data  = mmu_q[0];
      end else begin
        pin_valid = 1'b0;
      end
    end
  end

  // Downstream backpressure
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      po_ready     = 1'($urandom_range(0, 1));
      rs_ready     = 1'($urandom_range(0, 1));
      rl_out_ready = 1'($urandom_range(0, 1));
    end else begin
      po_ready     = 1'b1;
      rs_ready     = 1'b1;
      rl_out_ready = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    flag_fail("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  task automatic send_req(input logic [15:0] len, input logic [7:0] tag, input logic [9:0] free);
    int g;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_data   = len;
    req_tag    = tag;
    free_pages = free;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!o_pkt_req_tready && g < 5000);
    if (!o_pkt_req_tready) flag_fail("req_accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while ((exp_pg_q.size() != 0 || exp_rs_q.size() != 0 || exp_rl_q.size() != 0) && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (exp_pg_q.size() != 0 || exp_rs_q.size() != 0 || exp_rl_q.size() != 0)
      flag_fail("drain_timeout");
  endtask

  task automatic exp_page(input int d, input logic [7:0] tag, input logic last);
    exp_pg_q.push_back('{d: 10'(d), u: tag, l: last});
  endtask

  initial begin
    int nxt_pg;
    int len;
    int n;
    int g;
    logic [15:0] fixed_lens [6];
    fixed_lens = '{16'd1, 16'd2000, 16'd256, 16'd257, 16'd1999, 16'd768};
    sreset = 1'b1; free_pages = 10'd0; req_valid = 1'b0; req_data = 16'd0; req_tag = 8'd0;
    pin_valid = 1'b0; pin_data = 10'd0; po_ready = 1'b1; rs_ready = 1'b1;
    rl_in_valid = 1'b0; rl_in_data = 10'd0; rl_out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_tready_low", 32'(o_pkt_req_tready), 32'd0);
    chk("rst_tvalids", 32'({o_page_out_tvalid, o_pkt_resp_tvalid, o_release_out_tvalid}), 32'd0);
    @(posedge clk); #1;
    sreset = 1'b0;
    @(negedge clk);
    chk("idle_req_tready", 32'(o_pkt_req_tready), 32'd1);
    chk("idle_counters", 32'(o_cnt_bad | o_cnt_nospace), 32'd0);
    chk("idle_rel_tready", 32'(o_release_in_tready), 32'd1);

    // 600 B -> 3 pages; 4th MMU page must stay put
    mmu_q.push_back(10'd7); mmu_q.push_back(10'd8); mmu_q.push_back(10'd9); mmu_q.push_back(10'd10);
    exp_page(7, 8'h11, 1'b0); exp_page(8, 8'h11, 1'b0); exp_page(9, 8'h11, 1'b1);
    exp_rs_q.push_back({10'h003, 8'h11});
    send_req(16'd600, 8'h11, 10'd100);
    drain(500);
    repeat (5) @(negedge clk);
    chk("t1_mmu_left", 32'(mmu_q.size()), 32'd1);
    chk("t1_mmu_front", 32'(mmu_q[0]), 32'd10);

    // 512 then 513 back-to-back
    for (int i = 11; i <= 14; i++) mmu_q.push_back(10'(i));
    exp_page(10, 8'h22, 1'b0); exp_page(11, 8'h22, 1'b1);
    exp_page(12, 8'h23, 1'b0); exp_page(13, 8'h23, 1'b0); exp_page(14, 8'h23, 1'b1);
    exp_rs_q.push_back({10'h002, 8'h22});
    exp_rs_q.push_back({10'h003, 8'h23});
    send_req(16'd512, 8'h22, 10'd100);
    send_req(16'd513, 8'h23, 10'd100);
    drain(500);

    // length rejects with a page on offer
    mmu_q.push_back(10'd15);
    repeat (2) @(negedge clk);
    pin_rdy_seen = 1'b0;
    exp_rs_q.push_back({10'h200, 8'h30});
    exp_rs_q.push_back({10'h200, 8'h31});
    send_req(16'd0, 8'h30, 10'd100);
    send_req(16'd2001, 8'h31, 10'd100);
    drain(500);
    chk("t3_page_in_tready_seen", 32'(pin_rdy_seen), 32'd0);
    chk("t3_cnt_bad", o_cnt_bad, 32'd2);
    chk("t3_cnt_nospace", o_cnt_nospace, 32'd0);
    chk("t3_mmu_left", 32'(mmu_q.size()), 32'd1);

    // 1000 B needs 4 pages: 3 free rejects, 4 free admits
    mmu_q.push_back(10'd16); mmu_q.push_back(10'd17); mmu_q.push_back(10'd18);
    pin_rdy_seen = 1'b0;
    exp_rs_q.push_back({10'h100, 8'h40});
    send_req(16'd1000, 8'h40, 10'd3);
    drain(500);
    chk("t4_page_in_tready_seen", 32'(pin_rdy_seen), 32'd0);
    chk("t4_cnt_nospace", o_cnt_nospace, 32'd1);
    chk("t4_mmu_left", 32'(mmu_q.size()), 32'd4);
    for (int i = 15; i <= 18; i++) exp_page(i, 8'h41, 1'(i == 18));
    exp_rs_q.push_back({10'h004, 8'h41});
    send_req(16'd1000, 8'h41, 10'd4);
    drain(500);
    chk("t4_mmu_empty", 32'(mmu_q.size()), 32'd0);

    // random backpressure and MMU gaps, release traffic concurrent
    bp_en = 1'b1;
    gap_en = 1'b1;
    nxt_pg = 100;
    fork
      begin
        for (int p = 0; p < 24; p++) begin
          len = (p < 6) ? int'(fixed_lens[p]) : int'($urandom_range(1, 2000));
          n = (len + 255) / 256;
          for (int k = 0; k < n; k++) begin
            mmu_q.push_back(10'(nxt_pg));
            exp_page(nxt_pg, 8'(8'h60 + p), 1'(k == n - 1));
            nxt_pg++;
          end
          exp_rs_q.push_back({2'b00, 8'(n), 8'(8'h60 + p)});
          send_req(16'(len), 8'(8'h60 + p), 10'd1023);
        end
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
          rl_in_valid = 1'b1;
          rl_in_data  = 10'(i * 37 + 5);
          exp_rl_q.push_back(10'(i * 37 + 5));
          g = 0;
          do begin
            @(negedge clk);
            g++;
          end while (!o_release_in_tready && g < 200);
          if (!o_release_in_tready) flag_fail("release_accept_timeout");
          @(posedge clk); #1;
          if ($urandom_range(0, 3) == 0) begin
            rl_in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        rl_in_valid = 1'b0;
      end
    join
    drain(20000);
    bp_en = 1'b0;
    gap_en = 1'b0;
    repeat (3) @(posedge clk);

    // release latency with free-running tready
    @(posedge clk); #1;
    rl_in_valid = 1'b1;
    rl_in_data  = 10'h2A5;
    exp_rl_q.push_back(10'h2A5);
    @(negedge clk);
    chk("rel_in_ready_empty", 32'(o_release_in_tready), 32'd1);
    @(posedge clk); #1;
    rl_in_valid = 1'b0;
    @(negedge clk);
    chk("rel_latency_valid", 32'(o_release_out_tvalid), 32'd1);
    drain(100);

    // reset mid-ALLOC after one of three pages
    mmu_q.push_back(10'd200);
    exp_page(200, 8'h50, 1'b0);
    send_req(16'd700, 8'h50, 10'd100);
    g = 0;
    while (exp_pg_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (exp_pg_q.size() != 0) flag_fail("rst_first_page_timeout");
    @(posedge clk); #1;
    sreset = 1'b1;
    @(posedge clk); #1;
    sreset = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalids", 32'({o_page_out_tvalid, o_pkt_resp_tvalid, o_release_out_tvalid}), 32'd0);
    chk("rst_mid_cnt_bad", o_cnt_bad, 32'd0);
    chk("rst_mid_cnt_nospace", o_cnt_nospace, 32'd0);
    @(negedge clk);
    chk("rst_mid_req_tready", 32'(o_pkt_req_tready), 32'd1);
    mmu_q.push_back(10'd201);
    exp_page(201, 8'h51, 1'b1);
    exp_rs_q.push_back({10'h001, 8'h51});
    send_req(16'd256, 8'h51, 10'd100);
    drain(500);
    repeat (3) @(negedge clk);
    chk("rst_after_mmu_empty", 32'(mmu_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
